// File: rtl/io_in_dispatcher.sv
// Input-side dispatcher: buffers host samples in a FIFO and streams bursts of them
// onto the shared io_in bus, granting one requesting core at a time in round-robin order.
module io_in_dispatcher #(
    parameter int NUM_CORES  = 4,
    parameter int DATA_W     = 19,
    parameter int REQ_W      = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [DATA_W-1:0]      s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [NUM_CORES*REQ_W-1:0]    req_in_flat,
    output logic signed [DATA_W-1:0]      io_in,
    output logic [NUM_CORES-1:0]          in_grant,
    output logic                          in_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, BURST} state_t;
    state_t state_q, state_d;

    logic [DATA_W-1:0]          mem [FIFO_DEPTH];
    logic [AW-1:0]              wr_ptr, rd_ptr;
    logic [AW:0]                count;
    logic                       ready_en;
    logic                       push, pop, last_pop, grant_load;
    logic [NUM_CORES*REQ_W-1:0] req_q;
    logic [NUM_CORES-1:0]       rearm, eligible;
    logic [PW-1:0]              rr_ptr, winner;
    logic                       found;
    logic [REQ_W-1:0]           remaining;

    assign s_ready    = ready_en && (count < DEPTH_C);
    assign push       = s_valid && s_ready;
    assign pop        = (state_q == BURST) && (count != '0);
    assign last_pop   = pop && (remaining == REQ_W'(1));
    assign grant_load = (state_q == IDLE) && found;
    assign fifo_level = count;
    assign busy       = (state_q == BURST);

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_elig
        assign eligible[i] = (req_q[i*REQ_W +: REQ_W] != '0) && rearm[i];
    end

    // First eligible core at or after the round-robin pointer, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int off = 0; off < NUM_CORES; off++) begin
            if (!found && eligible[(int'(rr_ptr) + off) % NUM_CORES]) begin
                found  = 1'b1;
                winner = PW'((int'(rr_ptr) + off) % NUM_CORES);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found)    state_d = BURST;
            BURST:   if (last_pop) state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en  <= 1'b0;
            req_q     <= '0;
            rearm     <= '1;
            rr_ptr    <= '0;
            in_grant  <= '0;
            remaining <= '0;
            io_in     <= '0;
            in_valid  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            ready_en <= 1'b1;
            req_q    <= req_in_flat;
            in_valid <= 1'b0;
            // The grant stays up through the final word and drops in the following IDLE cycle.
            if (grant_load) begin
                in_grant  <= NUM_CORES'(1) << winner;
                remaining <= req_q[int'(winner)*REQ_W +: REQ_W];
                rr_ptr    <= (int'(winner) == NUM_CORES-1) ? '0 : winner + 1'b1;
            end else if (state_q == IDLE) begin
                in_grant <= '0;
            end
            if (pop) begin
                io_in     <= mem[rd_ptr];
                in_valid  <= 1'b1;
                remaining <= remaining - 1'b1;
                rd_ptr    <= rd_ptr + 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            // A zero request re-arms a core, so a held stale request is never served twice.
            for (int i = 0; i < NUM_CORES; i++) begin
                if (req_q[i*REQ_W +: REQ_W] == '0)  rearm[i] <= 1'b1;
                else if (last_pop && in_grant[i])  rearm[i] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_io_in_dispatcher.sv
// Directed bench for io_in_dispatcher: timing-exact burst checks plus a negedge monitor
// feeding a scoreboard of delivered words and their grants.
module tb_io_in_dispatcher;

    localparam int NUM_CORES  = 4;
    localparam int DATA_W     = 19;
    localparam int REQ_W      = 4;
    localparam int FIFO_DEPTH = 8;

    logic                         clk = 1'b0;
    logic                         rst = 1'b1;
    logic signed [DATA_W-1:0]     s_data = '0;
    logic                         s_valid = 1'b0;
    logic                         s_ready;
    logic [NUM_CORES*REQ_W-1:0]   req_in_flat = '0;
    logic signed [DATA_W-1:0]     io_in;
    logic [NUM_CORES-1:0]         in_grant;
    logic                         in_valid;
    logic [$clog2(FIFO_DEPTH):0]  fifo_level;
    logic                         busy;

    int n_checks = 0;
    int n_err    = 0;

    logic [DATA_W-1:0]    exp_q[$];
    logic [NUM_CORES-1:0] exp_g[$];
    logic [DATA_W-1:0]    got_data[$];
    logic [NUM_CORES-1:0] got_grant[$];

    io_in_dispatcher #(
        .NUM_CORES(NUM_CORES), .DATA_W(DATA_W), .REQ_W(REQ_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .req_in_flat(req_in_flat), .io_in(io_in), .in_grant(in_grant),
        .in_valid(in_valid), .fifo_level(fifo_level), .busy(busy)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor
    always @(negedge clk) begin
        if (!rst && in_valid) begin
            got_data.push_back(io_in);
            got_grant.push_back(in_grant);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int core, input logic [REQ_W-1:0] k);
        req_in_flat[core*REQ_W +: REQ_W] = k;
    endtask

    task automatic push_sample(input logic signed [DATA_W-1:0] v);
        s_data  = v;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        got_data.delete();
        got_grant.delete();
    endtask

    task automatic wait_words(input string tag, input int n, input int budget);
        int cyc = 0;
        while (got_data.size() < n && cyc < budget) begin
            step();
            cyc++;
        end
        check({tag, "_count"}, 32'(got_data.size()), 32'(n));
        while (got_data.size() > 0 && exp_q.size() > 0) begin
            check({tag, "_data"}, 32'(got_data.pop_front()), 32'(exp_q.pop_front()));
            check({tag, "_grant"}, 32'(got_grant.pop_front()), 32'(exp_g.pop_front()));
        end
        exp_q.delete();
        exp_g.delete();
        got_data.delete();
        got_grant.delete();
    endtask

    initial begin
        // Reset values while rst is held
        step();
        check("rst_s_ready", 32'(s_ready), 32'(0));
        check("rst_in_valid", 32'(in_valid), 32'(0));
        check("rst_in_grant", 32'(in_grant), 32'(0));
        check("rst_io_in", 32'(io_in), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        do_reset();
        check("post_rst_s_ready", 32'(s_ready), 32'(1));
        check("post_rst_level", 32'(fifo_level), 32'(0));

        // Core 1 burst of three
        push_sample(19'sd5);
        push_sample(-19'sd3);
        push_sample(19'sd7);
        check("t1_level3", 32'(fifo_level), 32'(3));
        set_req(1, 4'd3);
        step();
        check("t1_no_grant_yet", 32'(in_grant), 32'(0));
        step();
        check("t1_grant", 32'(in_grant), 32'(4'b0010));
        check("t1_busy", 32'(busy), 32'(1));
        check("t1_valid_at_grant", 32'(in_valid), 32'(0));
        step();
        check("t1_v0", 32'(in_valid), 32'(1));
        check("t1_w0", 32'(io_in), 32'(5));
        check("t1_level2", 32'(fifo_level), 32'(2));
        step();
        check("t1_v1", 32'(in_valid), 32'(1));
        check("t1_w1", 32'(io_in), 32'(-3));
        step();
        check("t1_v2", 32'(in_valid), 32'(1));
        check("t1_w2", 32'(io_in), 32'(7));
        check("t1_grant_last", 32'(in_grant), 32'(4'b0010));
        check("t1_level0", 32'(fifo_level), 32'(0));
        step();
        check("t1_idle_valid", 32'(in_valid), 32'(0));
        check("t1_idle_busy", 32'(busy), 32'(0));
        check("t1_idle_grant", 32'(in_grant), 32'(0));
        set_req(1, 4'd0);

        // Cores 0 and 2 held at 1 from reset; core 0 not re-served while held
        set_req(0, 4'd1);
        set_req(2, 4'd1);
        do_reset();
        for (int i = 0; i < 4; i++) push_sample(19'(11 + i));
        exp_q.push_back(19'd11); exp_g.push_back(4'b0001);
        exp_q.push_back(19'd12); exp_g.push_back(4'b0100);
        wait_words("t2_first", 2, 40);
        for (int i = 0; i < 10; i++) step();
        check("t2_no_reserve", 32'(got_data.size()), 32'(0));
        check("t2_level2", 32'(fifo_level), 32'(2));
        set_req(0, 4'd0);
        step();
        step();
        set_req(0, 4'd1);
        exp_q.push_back(19'd13); exp_g.push_back(4'b0001);
        wait_words("t2_rearm", 1, 20);
        set_req(0, 4'd0);
        set_req(2, 4'd0);

        // Empty FIFO: grant with stall, words one cycle after each push
        do_reset();
        set_req(3, 4'd2);
        step();
        step();
        check("t3_grant", 32'(in_grant), 32'(4'b1000));
        check("t3_stall0", 32'(in_valid), 32'(0));
        step();
        check("t3_stall1", 32'(in_valid), 32'(0));
        s_data = 19'sd9; s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        check("t3_push9_same", 32'(in_valid), 32'(0));
        check("t3_level1", 32'(fifo_level), 32'(1));
        step();
        check("t3_v9", 32'(in_valid), 32'(1));
        check("t3_w9", 32'(io_in), 32'(9));
        s_data = 19'sd11; s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        check("t3_stall_between", 32'(in_valid), 32'(0));
        check("t3_hold_io", 32'(io_in), 32'(9));
        check("t3_hold_grant", 32'(in_grant), 32'(4'b1000));
        step();
        check("t3_v11", 32'(in_valid), 32'(1));
        check("t3_w11", 32'(io_in), 32'(11));
        step();
        check("t3_done_busy", 32'(busy), 32'(0));
        set_req(3, 4'd0);

        // Full FIFO refuses pushes
        do_reset();
        for (int i = 0; i < FIFO_DEPTH; i++) push_sample(19'(100 + i));
        check("t4_level8", 32'(fifo_level), 32'(8));
        check("t4_not_ready", 32'(s_ready), 32'(0));
        push_sample(19'sd999);
        check("t4_level_still8", 32'(fifo_level), 32'(8));
        set_req(0, 4'd1);
        step();
        step();
        step();
        check("t4_pop_valid", 32'(in_valid), 32'(1));
        check("t4_pop_head", 32'(io_in), 32'(100));
        check("t4_level7", 32'(fifo_level), 32'(7));
        check("t4_ready_again", 32'(s_ready), 32'(1));
        set_req(0, 4'd0);

        // Asynchronous reset mid-burst
        do_reset();
        for (int i = 1; i <= 5; i++) push_sample(19'(i));
        set_req(2, 4'd5);
        step();
        step();
        check("t5_grant", 32'(in_grant), 32'(4'b0100));
        step();
        step();
        check("t5_w2", 32'(io_in), 32'(2));
        rst = 1'b1;
        #1;
        check("t5_async_valid", 32'(in_valid), 32'(0));
        check("t5_async_grant", 32'(in_grant), 32'(0));
        check("t5_async_io", 32'(io_in), 32'(0));
        check("t5_async_busy", 32'(busy), 32'(0));
        check("t5_async_level", 32'(fifo_level), 32'(0));
        check("t5_async_ready", 32'(s_ready), 32'(0));
        set_req(2, 4'd0);
        step();
        rst = 1'b0;
        step();
        check("t5_rel_level", 32'(fifo_level), 32'(0));
        check("t5_rel_ready", 32'(s_ready), 32'(1));
        push_sample(19'sd42);
        set_req(0, 4'd1);
        set_req(3, 4'd1);
        step();
        step();
        step();
        check("t5_ptr_valid", 32'(in_valid), 32'(1));
        check("t5_ptr_core0", 32'(in_grant), 32'(4'b0001));
        check("t5_ptr_word", 32'(io_in), 32'(42));
        set_req(0, 4'd0);
        set_req(3, 4'd0);
        step();

        // Report
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
